modulo_fold_encoder: RTL and testbench
======================================

Name: modulo_fold_encoder

Overview:
- Behavioural/synthesizable model of a self-reset (modulo) ADC front end: the forward direction of the USF unlimited-sampling chain.
- Takes a high-dynamic-range signed fixed-point sample and folds it into [-LAMBDA, LAMBDA) by repeated ±2·LAMBDA correction.
- Quantizes the folded value to a 12-bit offset-binary code using the same start/clk_en framing as reconstruction_top.
- Drives reconstruction_top's adc_in in closed-loop benches, and feeds the DAC path on hardware.

Parameters:
WIDTH, 24, input sample width, signed two's complement, Q(WIDTH-FRACTIONAL_BITS).FRACTIONAL_BITS
FRACTIONAL_BITS, 16, fractional bits of sample_in and LAMBDA
LAMBDA, 24'h00C000, fold threshold (0.75 in Q8.16); positive, nonzero
MAX_FOLDS, 127, maximum fold iterations per conversion
ADC_SCALE, 2731, round(4096·2^SCALE_SHIFT/(2·LAMBDA))
SCALE_SHIFT, 16, right shift applied after the ADC_SCALE multiply

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
clk_en  in  1  FSM advance enable; low freezes all state except valid_out
start  in  1  conversion request, sampled in IDLE with clk_en=1
sample_in  in  WIDTH  signed input sample, captured on accepted start
busy  out  1  high from the accepted start until the QUANT cycle completes
valid_out  out  1  one-cycle pulse: adc_out/fold_count/overflow updated
adc_out  out  12  offset-binary code of the folded sample; held until next valid_out
fold_count  out  8  signed net fold count (+1 per subtract, -1 per add)
overflow  out  1  MAX_FOLDS reached with value still out of range

Behaviour:
- Reset values:
  - state = IDLE.
  - busy, valid_out, adc_out, fold_count, overflow = 0.
  - Internal accumulator = 0.
  - Reset mid-conversion aborts immediately; no valid_out is produced.
- Internal accumulator x: signed WIDTH+2 bits; sample_in is sign-extended into it. Iteration counter: 8 bits.
- IDLE:
  - On an edge with clk_en=1 and start=1: x <= sample_in, fold_count and iteration counter cleared, busy <= 1, go to FOLD.
  - start with clk_en=0 is ignored.
- FOLD: one correction per enabled cycle.
  - If x >= LAMBDA: x -= 2·LAMBDA, fold_count += 1.
  - Else if x < -LAMBDA: x += 2·LAMBDA, fold_count -= 1.
  - Else: go to QUANT.
  - If the iteration counter reaches MAX_FOLDS while x is still out of range:
    - overflow <= 1.
    - x saturates to LAMBDA-1 if positive, otherwise -LAMBDA.
    - go to QUANT.
- QUANT (one enabled cycle):
  - adc_out <= clamp(((x+LAMBDA)·ADC_SCALE) >>> SCALE_SHIFT, 0, 4095).
  - valid_out <= 1, busy <= 0, go to IDLE.
- Latency: valid_out is high after enabled edge k+2+n, where k is the start-accept edge and n is the number of folds. An in-range input therefore takes 2 cycles.
- valid_out clears on the very next clk edge regardless of clk_en.
- clk_en=0 in FOLD or QUANT: state, x, counters and outputs hold; latency extends by the stalled cycles.
- start while busy: ignored; the in-flight conversion is unaffected.
- start and a QUANT completion on the same edge: start is not accepted. IDLE is entered first, so the start must be held or re-asserted.
- Boundary rules:
  - x == LAMBDA folds.
  - x == -LAMBDA does not fold.
  - x == LAMBDA-1 gives code 4095 after the clamp.
- overflow is updated at every valid_out and cleared on the next accepted start.

Test Plan:
- sample_in=0 → adc_out=2048, fold_count=0, overflow=0; valid_out exactly 2 cycles after start; busy high for those 2 cycles.
- sample_in=24'h010000 (1.0) → x=-0.5, adc_out=682, fold_count=+1, latency 3. sample_in=-24'h010000 → adc_out=3413, fold_count=-1.
- Boundaries:
  - sample_in=24'h00C000 → one fold to -LAMBDA, adc_out=0, fold_count=1.
  - sample_in=24'h00BFFF → no fold, adc_out=4095.
  - sample_in=-24'h00C000 → no fold, adc_out=0.
- sample_in=24'h400000 (64.0) → 43 folds, adc_out=682, fold_count=43, valid_out 45 cycles after start. With MAX_FOLDS=4 the same input → overflow=1, adc_out=4095, fold_count=4.
- Stall and abort:
  - Drop clk_en for 5 cycles mid-FOLD → outputs frozen, valid_out delayed by exactly 5 cycles, result unchanged.
  - Pulse start mid-FOLD → ignored.
  - Assert reset mid-FOLD → busy=0, no valid_out, all outputs 0.
- Closed loop: drive adc_out into reconstruction_top (LAMBDA=24'h00C000, FRACTIONAL_BITS=16) with slow ramp 0→3.0. Reconstructed dac_out tracks the input within one ADC LSB scaled.

Source files
------------

// File: rtl/modulo_fold_encoder.sv
// Self-reset (modulo) ADC front end: folds a wide signed sample into [-LAMBDA, LAMBDA)
// and quantizes the folded value to a 12-bit offset-binary code.
module modulo_fold_encoder #(
    parameter int unsigned          WIDTH           = 24,
    parameter int unsigned          FRACTIONAL_BITS = 16,
    parameter logic [WIDTH-1:0]     LAMBDA          = 24'h00C000,
    parameter int unsigned          MAX_FOLDS       = 127,
    parameter int unsigned          ADC_SCALE       = 2731,
    parameter int unsigned          SCALE_SHIFT     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             start,
    input  logic [WIDTH-1:0] sample_in,
    output logic             busy,
    output logic             valid_out,
    output logic [11:0]      adc_out,
    output logic [7:0]       fold_count,
    output logic             overflow
);

    localparam int unsigned XW = WIDTH + 2;
    localparam int unsigned PW = XW + 1 + 33;

    localparam logic signed [XW-1:0] LAM_X    = $signed({2'b00, LAMBDA});
    localparam logic signed [XW-1:0] TWO_LAM  = LAM_X <<< 1;
    localparam logic signed [XW-1:0] NEG_LAM  = -LAM_X;
    localparam logic signed [XW-1:0] SAT_POS  = LAM_X - XW'(1);
    localparam logic        [7:0]    MAX_IT   = 8'(MAX_FOLDS);
    localparam logic signed [PW-1:0] SCALE_W  = PW'(ADC_SCALE);
    localparam logic signed [PW-1:0] CODE_MAX = PW'(4095);

    // Elaboration-time sanity checks on the fixed-point format
    if (FRACTIONAL_BITS >= WIDTH) begin : g_bad_frac
        $error("FRACTIONAL_BITS must be smaller than WIDTH");
    end
    if (LAMBDA == '0) begin : g_bad_lambda
        $error("LAMBDA must be nonzero");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FOLD  = 2'd1,
        S_QUANT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic signed [XW-1:0]   x_q, x_d;
    logic        [7:0]      iter_q, iter_d;
    logic signed [7:0]      fold_q, fold_d;
    logic                   busy_q, busy_d;
    logic                   valid_q, valid_d;
    logic        [11:0]     adc_q, adc_d;
    logic                   ovf_q, ovf_d;

    logic                   x_ge_c, x_lt_c;
    logic signed [XW:0]     qsum_c;
    logic signed [PW-1:0]   prod_c, scaled_c;
    logic        [11:0]     code_c;

    assign x_ge_c = (x_q >= LAM_X);
    assign x_lt_c = (x_q < NEG_LAM);

    // Offset-binary quantizer: (x + LAMBDA) * scale >>> shift, clamped to 12 bits
    always_comb begin
        qsum_c   = {x_q[XW-1], x_q} + {LAM_X[XW-1], LAM_X};
        prod_c   = PW'(qsum_c) * SCALE_W;
        scaled_c = prod_c >>> SCALE_SHIFT;
        if (scaled_c[PW-1]) begin
            code_c = 12'd0;
        end else if (scaled_c > CODE_MAX) begin
            code_c = 12'd4095;
        end else begin
            code_c = 12'(scaled_c);
        end
    end

    // Next-state and register updates; clk_en gates everything except the valid pulse
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        iter_d  = iter_q;
        fold_d  = fold_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        adc_d   = adc_q;
        ovf_d   = ovf_q;
        if (clk_en) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        x_d     = $signed({{2{sample_in[WIDTH-1]}}, sample_in});
                        iter_d  = '0;
                        fold_d  = '0;
                        ovf_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = S_FOLD;
                    end
                end
                S_FOLD: begin
                    if (x_ge_c || x_lt_c) begin
                        if (iter_q == MAX_IT) begin
                            ovf_d   = 1'b1;
                            x_d     = x_ge_c ? SAT_POS : NEG_LAM;
                            state_d = S_QUANT;
                        end else if (x_ge_c) begin
                            x_d    = x_q - TWO_LAM;
                            fold_d = fold_q + 8'sd1;
                            iter_d = iter_q + 8'd1;
                        end else begin
                            x_d    = x_q + TWO_LAM;
                            fold_d = fold_q - 8'sd1;
                            iter_d = iter_q + 8'd1;
                        end
                    end else begin
                        state_d = S_QUANT;
                    end
                end
                S_QUANT: begin
                    adc_d   = code_c;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            iter_q  <= '0;
            fold_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            adc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            iter_q  <= iter_d;
            fold_q  <= fold_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            adc_q   <= adc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy       = busy_q;
    assign valid_out  = valid_q;
    assign adc_out    = adc_q;
    assign fold_count = fold_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_modulo_fold_encoder.sv
// Self-checking bench for modulo_fold_encoder: directed vectors, stall/abort sequences
// and random samples checked against an arithmetic fold/quantize model.
module tb_modulo_fold_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic        start_a, start_b;
    logic [23:0] sample_in;
    logic        busy_a, valid_a, ovf_a, busy_b, valid_b, ovf_b;
    logic [11:0] adc_a, adc_b;
    logic [7:0]  fold_a, fold_b;
    bit          use_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    modulo_fold_encoder dut_a (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start_a), .sample_in(sample_in),
        .busy(busy_a), .valid_out(valid_a), .adc_out(adc_a), .fold_count(fold_a), .overflow(ovf_a)
    );

    modulo_fold_encoder #(.MAX_FOLDS(4)) dut_b (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start_b), .sample_in(sample_in),
        .busy(busy_b), .valid_out(valid_b), .adc_out(adc_b), .fold_count(fold_b), .overflow(ovf_b)
    );

    wire        busy_m  = use_b ? busy_b  : busy_a;
    wire        valid_m = use_b ? valid_b : valid_a;
    wire        ovf_m   = use_b ? ovf_b   : ovf_a;
    wire [11:0] adc_m   = use_b ? adc_b   : adc_a;
    wire [7:0]  fold_m  = use_b ? fold_b  : fold_a;

    task automatic chk(input string name, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Closed-form reference: fold = ((x+L) mod 2L) - L, net folds = (x - fold)/2L
    function automatic void model(input logic [23:0] s, input int maxf,
                                  output int code, output int folds, output bit ovf);
        longint x, L, twoL, r, f, n, p;
        x    = longint'($signed(s));
        L    = 49152;
        twoL = 2 * L;
        r    = (x + L) % twoL;
        if (r < 0) r += twoL;
        f = r - L;
        n = (x - f) / twoL;
        ovf = 1'b0;
        if (n > maxf) begin
            ovf = 1'b1; folds = maxf; f = L - 1;
        end else if (n < -maxf) begin
            ovf = 1'b1; folds = -maxf; f = -L;
        end else begin
            folds = int'(n);
        end
        p = ((f + L) * 2731) / 65536;
        code = (p > 4095) ? 4095 : int'(p);
    endfunction

    task automatic convert(input logic [23:0] s, input bit b, input int stall_at,
                           input int stall_len, input int pulse_at,
                           output int code, output int folds, output bit ovf,
                           output int lat, output int busy_cnt, output bit busy_end);
        bit done;
        use_b = b;
        @(negedge clk);
        sample_in = s;
        if (b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        lat = 0; busy_cnt = 0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            start_a = 1'b0; start_b = 1'b0;
            if (valid_m) begin
                done = 1'b1;
            end else begin
                if (busy_m) busy_cnt++;
                if (stall_len > 0 && lat == stall_at) clk_en = 1'b0;
                if (stall_len > 0 && lat == stall_at + stall_len) begin
                    clk_en = 1'b1;
                    chk("fold_count frozen during stall", longint'($signed(fold_m)), stall_at);
                end
                if (lat == pulse_at) begin
                    sample_in = 24'h000000;
                    if (b) start_b = 1'b1; else start_a = 1'b1;
                end
                @(posedge clk);
                lat++;
                if (lat > 300) begin
                    chk("valid_out timeout", lat, 0);
                    done = 1'b1;
                end
            end
        end
        code     = int'(adc_m);
        folds    = int'($signed(fold_m));
        ovf      = ovf_m;
        busy_end = busy_m;
    endtask

    typedef struct {
        logic [23:0] sample;
        bit          b;
        int          code;
        int          folds;
        bit          ovf;
        int          lat;
    } vec_t;

    initial begin
        vec_t vt[9];
        int   code, folds, lat, bcnt, ecode, efolds, nvalid;
        bit   ovf, bend, eovf;
        logic [23:0] s;

        vt[0] = '{24'h000000, 1'b0, 2048,  0, 1'b0,  2};
        vt[1] = '{24'h010000, 1'b0,  682,  1, 1'b0,  3};
        vt[2] = '{24'hFF0000, 1'b0, 3413, -1, 1'b0,  3};
        vt[3] = '{24'h00C000, 1'b0,    0,  1, 1'b0,  3};
        vt[4] = '{24'h00BFFF, 1'b0, 4095,  0, 1'b0,  2};
        vt[5] = '{24'hFF4000, 1'b0,    0,  0, 1'b0,  2};
        vt[6] = '{24'h400000, 1'b0,  682, 43, 1'b0, 45};
        vt[7] = '{24'h400000, 1'b1, 4095,  4, 1'b1,  6};
        vt[8] = '{24'hC00000, 1'b1,    0, -4, 1'b1,  6};

        reset = 1'b1; clk_en = 1'b1; start_a = 1'b0; start_b = 1'b0;
        sample_in = '0; use_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset busy", busy_a, 0);
        chk("reset valid_out", valid_a, 0);
        chk("reset adc_out", adc_a, 0);
        chk("reset fold_count", fold_a, 0);
        chk("reset overflow", ovf_b, 0);

        // start while clk_en is low must not launch a conversion
        clk_en = 1'b0; start_a = 1'b1; sample_in = 24'h010000;
        repeat (3) @(negedge clk);
        chk("start ignored with clk_en=0", busy_a, 0);
        start_a = 1'b0; clk_en = 1'b1;

        foreach (vt[i]) begin
            convert(vt[i].sample, vt[i].b, -1, 0, -1, code, folds, ovf, lat, bcnt, bend);
            chk($sformatf("vec%0d adc_out", i), code, vt[i].code);
            chk($sformatf("vec%0d fold_count", i), folds, vt[i].folds);
            chk($sformatf("vec%0d overflow", i), ovf, vt[i].ovf);
            chk($sformatf("vec%0d latency", i), lat, vt[i].lat);
            chk($sformatf("vec%0d busy cycles", i), bcnt, vt[i].lat);
            chk($sformatf("vec%0d busy at valid", i), bend, 0);
        end

        // 5-cycle clk_en stall mid-FOLD: same result, latency +5
        convert(24'h400000, 1'b0, 10, 5, -1, code, folds, ovf, lat, bcnt, bend);
        chk("stall adc_out", code, 682);
        chk("stall fold_count", folds, 43);
        chk("stall latency", lat, 50);

        // start pulse mid-FOLD is ignored
        convert(24'h400000, 1'b0, -1, 0, 5, code, folds, ovf, lat, bcnt, bend);
        chk("midfold start adc_out", code, 682);
        chk("midfold start fold_count", folds, 43);
        chk("midfold start latency", lat, 45);
        repeat (3) @(negedge clk);
        chk("midfold start no relaunch", busy_a, 0);

        // random samples against the model on both fold limits
        for (int i = 0; i < 40; i++) begin
            s = 24'($urandom);
            model(s, (i >= 28) ? 4 : 127, ecode, efolds, eovf);
            convert(s, i >= 28, -1, 0, -1, code, folds, ovf, lat, bcnt, bend);
            chk($sformatf("rand%0d adc_out s=%h", i, s), code, ecode);
            chk($sformatf("rand%0d fold_count s=%h", i, s), folds, efolds);
            chk($sformatf("rand%0d overflow s=%h", i, s), ovf, eovf);
            chk($sformatf("rand%0d latency s=%h", i, s), lat,
                2 + ((efolds < 0) ? -efolds : efolds));
        end

        // reset mid-FOLD aborts with no valid_out
        use_b = 1'b0;
        @(negedge clk);
        sample_in = 24'h400000; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy", busy_a, 0);
        chk("abort valid_out", valid_a, 0);
        chk("abort adc_out", adc_a, 0);
        chk("abort fold_count", fold_a, 0);
        chk("abort overflow", ovf_a, 0);
        nvalid = 0;
        repeat (60) begin
            @(negedge clk);
            if (valid_a) nvalid++;
        end
        chk("abort no valid_out", nvalid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
